// File: rtl/timer_ctrl.sv
// timer_ctrl: run/pause/done sequencer for a BCD down-counter, with tick prescaler
// Ports: clk, rst_n (sync, active low), start_stop/clr (one-cycle pulses),
// count_zero (datapath all-zero), cnt_en (decrement pulse), cnt_load (reload pulse),
// alarm (high in DONE), state (IDLE=00 RUN=01 PAUSE=10 DONE=11).
// Optional macro TIMER_AUTO_RELOAD_EN: leave DONE for RUN after ALARM_CYCLES cycles.
module timer_ctrl #(
  parameter int TICK_DIV     = 100000000,
  parameter int ALARM_CYCLES = 300000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clr,
  input  logic       count_zero,
  output logic       cnt_en,
  output logic       cnt_load,
  output logic       alarm,
  output logic [1:0] state
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t cur, nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic term, reload, en_nxt, load_nxt;
  assign term  = presc == PW'(TICK_DIV - 1);
  assign state = cur;
`ifdef TIMER_AUTO_RELOAD_EN
  localparam int AW = ALARM_CYCLES > 1 ? $clog2(ALARM_CYCLES) : 1;
  logic [AW-1:0] acnt;
  assign reload = cur == DONE && acnt == AW'(ALARM_CYCLES - 1);
  // zero outside DONE, so it starts from 0 on every DONE entry
  always_ff @(posedge clk)
    if (!rst_n) acnt <= '0;
    else acnt <= cur == DONE ? acnt + AW'(1) : '0;
`else
  assign reload = 1'b0 && ALARM_CYCLES != 0;
`endif
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (start_stop) nxt = count_zero ? DONE : RUN;
      RUN:     nxt = start_stop ? PAUSE : count_zero ? DONE : RUN;
      PAUSE:   if (start_stop) nxt = RUN;
      DONE:    nxt = start_stop ? IDLE : reload ? RUN : DONE;
      default: nxt = IDLE;
    endcase
    if (clr) nxt = IDLE;
    // ticks only while staying in RUN, so a pause on the terminal count keeps it
    en_nxt    = cur == RUN && nxt == RUN && term;
    load_nxt  = clr || (cur == DONE && nxt != DONE);
    presc_nxt = (nxt == IDLE || (nxt == RUN && (cur == IDLE || cur == DONE))) ? '0 :
                (cur == RUN && nxt == RUN) ? (term ? '0 : presc + PW'(1)) : presc;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cur      <= IDLE;
      presc    <= '0;
      cnt_en   <= 1'b0;
      cnt_load <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      cur      <= nxt;
      presc    <= presc_nxt;
      cnt_en   <= en_nxt;
      cnt_load <= load_nxt;
      alarm    <= nxt == DONE;
    end
endmodule
